// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM SRAM port arbiter: FSM states, owner encoding, default widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

endpackage

// File: rtl/arb_select.sv
// Combinational winner pick between IF and MEM requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority on conflict; otherwise MEM always wins.
module arb_select
   import mem_arb_pkg::*;
(
   input  logic if_req_i,
   input  logic mem_req_i,
   input  logic last_grant_i,
   output logic grant_vld_o,
   output logic grant_o
);

   assign grant_vld_o = if_req_i | mem_req_i;

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant_o = OWN_IF;
      if (if_req_i && mem_req_i)
         grant_o = (last_grant_i == OWN_MEM) ? OWN_IF : OWN_MEM;
      else if (mem_req_i)
         grant_o = OWN_MEM;
   end
`else
   // MEM holds the older instruction, so it always goes first; history is irrelevant here.
   logic last_grant_unused;
   assign last_grant_unused = last_grant_i;

   always_comb begin
      grant_o = OWN_IF;
      if (mem_req_i)
         grant_o = OWN_MEM;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM controller port between the IF and MEM pipeline stages, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              sram_req,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_ack
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              sram_req_q, sram_req_d;
   logic              sram_we_q, sram_we_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

   logic mem_req;
   logic grant_vld;
   logic grant;
   logic last_grant;

   assign mem_req = mem_rd | mem_wr;

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_grant_q, last_grant_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant_q <= OWN_IF;
      else
         last_grant_q <= last_grant_d;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == ARB_IDLE && grant_vld)
         last_grant_d = owner_e'(grant);
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = OWN_IF;
`endif

   arb_select u_sel (
      .if_req_i     (if_req),
      .mem_req_i    (mem_req),
      .last_grant_i (last_grant),
      .grant_vld_o  (grant_vld),
      .grant_o      (grant)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_IF;
         sram_req_q   <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         sram_req_q   <= sram_req_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      sram_req_d   = sram_req_q;
      sram_we_d    = sram_we_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            if (grant_vld) begin
               state_d    = ARB_BUSY;
               sram_req_d = 1'b1;
               owner_d    = owner_e'(grant);
               // rd+wr together is illegal upstream; letting mem_wr win makes it a write.
               if (grant == OWN_MEM) begin
                  sram_we_d    = mem_wr;
                  sram_addr_d  = mem_addr;
                  sram_wdata_d = mem_wdata;
               end else begin
                  sram_we_d    = 1'b0;
                  sram_addr_d  = if_addr;
                  sram_wdata_d = '0;
               end
            end
         end
         ARB_BUSY: begin
            if (sram_ack) begin
               state_d    = ARB_RESP;
               sram_req_d = 1'b0;
               if (!sram_we_q) begin
                  if (owner_q == OWN_IF)
                     if_rdata_d = sram_rdata;
                  else
                     mem_rdata_d = sram_rdata;
               end
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // A stage with no request is never stalled; a requesting stage waits for its RESP cycle.
   assign if_ready  = ~if_req  | (state_q == ARB_RESP && owner_q == OWN_IF);
   assign mem_ready = ~mem_req | (state_q == ARB_RESP && owner_q == OWN_MEM);

   assign sram_req   = sram_req_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign if_rdata   = if_rdata_q;
   assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural SRAM controller; honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        sram_req;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ack;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .sram_ack(sram_ack)
   );

   typedef struct {logic own; logic [31:0] data;} resp_t;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} sreq_t;

   int    checks = 0;
   int    errors = 0;
   resp_t exp_resp[$];
   sreq_t exp_sreq[$];
   logic [31:0] smem [logic [31:0]];
   int    ack_dly = 2;
   int    ack_cnt = -1;
   bit    spur = 1'b0;
   logic  prev_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_resp(input logic own, input logic [31:0] data);
      resp_t e;
      if (exp_resp.size() == 0) begin
         checks++; errors++;
         $display("FAIL resp: unexpected ready owner %0d data %h", own, data);
      end else begin
         e = exp_resp.pop_front();
         chk("resp_owner", {31'd0, own}, {31'd0, e.own});
         chk("resp_data", data, e.data);
      end
   endtask

   task automatic push_sreq(input logic we, input logic [31:0] a, input logic [31:0] d);
      sreq_t s;
      s.we = we; s.addr = a; s.wdata = d;
      exp_sreq.push_back(s);
   endtask

   task automatic push_resp(input logic own, input logic [31:0] d);
      resp_t r;
      r.own = own; r.data = d;
      exp_resp.push_back(r);
   endtask

   task automatic wait_ready(input logic own, output int cyc);
      logic rdy;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         rdy = (own == OWN_MEM) ? mem_ready : if_ready;
      end while (!rdy && cyc < 200);
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL ready_timeout: owner %0d no ready after %0d cycles", own, cyc);
      end
   endtask

   task automatic wait_sram_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sram_req && n < 20);
      chk("sram_req_rise", {31'd0, sram_req}, 32'd1);
   endtask

   task automatic drop(input logic own);
      @(posedge clk); #1;
      if (own == OWN_MEM) begin mem_rd = 1'b0; mem_wr = 1'b0; end
      else if_req = 1'b0;
   endtask

   task automatic if_read(input logic [31:0] a, input logic [31:0] exp, output int cyc);
      @(posedge clk); #1;
      push_sreq(1'b0, a, 32'd0);
      push_resp(OWN_IF, exp);
      if_addr = a; if_req = 1'b1;
      wait_ready(OWN_IF, cyc);
      drop(OWN_IF);
   endtask

   task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
      int cyc;
      @(posedge clk); #1;
      push_sreq(wr, a, d);
      push_resp(OWN_MEM, exp);
      mem_addr = a; mem_wdata = d; mem_rd = rd; mem_wr = wr;
      wait_ready(OWN_MEM, cyc);
      drop(OWN_MEM);
   endtask

   // Behavioural SRAM controller: ack ack_dly cycles after the request is first seen.
   initial begin
      sram_ack = 1'b0;
      sram_rdata = '1;
      forever begin
         @(negedge clk);
         sram_ack = 1'b0;
         if (!rst) ack_cnt = -1;
         else if (spur) begin
            spur = 1'b0; sram_ack = 1'b1; sram_rdata = 32'hCAFEBABE;
         end else if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               sram_ack = 1'b1; ack_cnt = -1;
               if (sram_we) smem[sram_addr] = sram_wdata;
               else sram_rdata = smem.exists(sram_addr) ? smem[sram_addr] : 32'hDEAD0000;
            end
         end else if (sram_req && ack_cnt < 0) ack_cnt = ack_dly;
      end
   end

   // Monitor: new SRAM requests and ready pulses of active requesters.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (sram_req && !prev_req) begin
               if (exp_sreq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sram_req: unexpected request addr %h", sram_addr);
               end else begin
                  sreq_t e;
                  e = exp_sreq.pop_front();
                  chk("sram_we", {31'd0, sram_we}, {31'd0, e.we});
                  chk("sram_addr", sram_addr, e.addr);
                  if (e.we) chk("sram_wdata", sram_wdata, e.wdata);
               end
            end
            if (if_req && if_ready) check_resp(OWN_IF, if_rdata);
            if ((mem_rd || mem_wr) && mem_ready) check_resp(OWN_MEM, mem_rdata);
         end
         prev_req = sram_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic first;
      smem[32'h40] = 32'hE3A01005;
      smem[32'h44] = 32'hE59F1010;
      smem[32'h48] = 32'hE1A00000;

      // Reset state
      #12;
      chk("rst_sram_req", {31'd0, sram_req}, 32'd0);
      chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
      chk("rst_sram_addr", sram_addr, 32'd0);
      chk("rst_sram_wdata", sram_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
      chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
      if_req = 1'b1; #1;
      chk("rst_if_ready_req", {31'd0, if_ready}, 32'd0);
      if_req = 1'b0;
      @(negedge clk); #1 rst = 1'b1;

      // IF read: request -> sram_req next cycle, ack 2 later, ready one after
      if_read(32'h40, 32'hE3A01005, cyc);
      chk("if_latency", cyc, 32'd5);

      // MEM write leaves mem_rdata untouched
      mem_op(1'b0, 1'b1, 32'h400, 32'h12345678, 32'd0);
      chk("sram_written", smem[32'h400], 32'h12345678);

      // Simultaneous IF + MEM read
`ifdef ARB_ROUND_ROBIN_EN
      first = OWN_IF;
`else
      first = OWN_MEM;
`endif
      @(posedge clk); #1;
      if (first == OWN_MEM) begin
         push_sreq(1'b0, 32'h400, 32'd0); push_resp(OWN_MEM, 32'h12345678);
         push_sreq(1'b0, 32'h44, 32'd0);  push_resp(OWN_IF, 32'hE59F1010);
      end else begin
         push_sreq(1'b0, 32'h44, 32'd0);  push_resp(OWN_IF, 32'hE59F1010);
         push_sreq(1'b0, 32'h400, 32'd0); push_resp(OWN_MEM, 32'h12345678);
      end
      if_addr = 32'h44; mem_addr = 32'h400;
      if_req = 1'b1; mem_rd = 1'b1;
      wait_ready(first, cyc);
      drop(first);
      wait_ready(~first, cyc);
      drop(~first);

      // Ack withheld for 20 cycles: everything holds
      ack_dly = 22;
      smem[32'h4C] = 32'hE2811001;
      @(posedge clk); #1;
      push_sreq(1'b0, 32'h4C, 32'd0); push_resp(OWN_IF, 32'hE2811001);
      if_addr = 32'h4C; if_req = 1'b1;
      wait_sram_req();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_sram_req", {31'd0, sram_req}, 32'd1);
         chk("hold_sram_addr", sram_addr, 32'h4C);
         chk("hold_if_ready", {31'd0, if_ready}, 32'd0);
         chk("hold_if_rdata", if_rdata, 32'hE59F1010);
      end
      wait_ready(OWN_IF, cyc);
      drop(OWN_IF);
      ack_dly = 2;

      // Reset during ARB_BUSY, then the held IF request is re-arbitrated
      ack_dly = 5;
      @(posedge clk); #1;
      push_sreq(1'b0, 32'h48, 32'd0);
      push_sreq(1'b0, 32'h48, 32'd0);
      push_resp(OWN_IF, 32'hE1A00000);
      if_addr = 32'h48; if_req = 1'b1;
      wait_sram_req();
      #1 rst = 1'b0;
      #1;
      chk("arst_sram_req", {31'd0, sram_req}, 32'd0);
      chk("arst_sram_addr", sram_addr, 32'd0);
      chk("arst_if_rdata", if_rdata, 32'd0);
      chk("arst_mem_rdata", mem_rdata, 32'd0);
      chk("arst_if_ready", {31'd0, if_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk); #1 rst = 1'b1;
      wait_ready(OWN_IF, cyc);
      drop(OWN_IF);
      ack_dly = 2;

      // Spurious ack while idle is ignored
      @(posedge clk); #1 spur = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("spur_sram_req", {31'd0, sram_req}, 32'd0);
         chk("spur_if_ready", {31'd0, if_ready}, 32'd1);
         chk("spur_mem_ready", {31'd0, mem_ready}, 32'd1);
         chk("spur_if_rdata", if_rdata, 32'hE1A00000);
         chk("spur_mem_rdata", mem_rdata, 32'd0);
      end
      if_read(32'h40, 32'hE3A01005, cyc);
      chk("post_spur_latency", cyc, 32'd5);

      // Illegal rd+wr is a write; mem_rdata unchanged
      mem_op(1'b1, 1'b1, 32'h500, 32'hA5A5A5A5, 32'd0);
      chk("rdwr_written", smem[32'h500], 32'hA5A5A5A5);

      repeat (5) @(negedge clk);
      chk("resp_q_empty", exp_resp.size(), 32'd0);
      chk("sreq_q_empty", exp_sreq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single SRAM controller port between the instruction-fetch requester (IF stage) and the data-memory requester (MEM stage) of the ARM pipeline. It arbitrates, latches the winning request, holds it on the SRAM request/acknowledge handshake, and returns data with a one-cycle per-requester `ready` pulse. Each stage freezes while its `ready` is low, the same way the pipeline registers do today.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  IF read request (level, held until `if_ready`)
- `if_addr`  in  ADDR_W  IF read address
- `if_rdata`  out  DATA_W  IF read data, registered
- `if_ready`  out  1  IF may advance
- `mem_rd`  in  1  MEM read request (level)
- `mem_wr`  in  1  MEM write request (level)
- `mem_addr`  in  ADDR_W  MEM address
- `mem_wdata`  in  DATA_W  MEM write data
- `mem_rdata`  out  DATA_W  MEM read data, registered
- `mem_ready`  out  1  MEM may advance
- `sram_req`  out  1  request to SRAM controller, registered
- `sram_we`  out  1  1 = write
- `sram_addr`  out  ADDR_W  latched address
- `sram_wdata`  out  DATA_W  latched write data
- `sram_rdata`  in  DATA_W  SRAM read data, valid with `sram_ack`
- `sram_ack`  in  1  one-cycle completion pulse

## Operation
- FSM states: ARB_IDLE, ARB_BUSY, ARB_RESP. `owner` register: IF or MEM.
- ARB_IDLE: if any request is present, pick a winner. Latch its address, write data and `we` into the `sram_*` registers. Set `owner`. Go to ARB_BUSY.
- ARB_BUSY: `sram_req`=1 and the latched fields are held stable. On `sram_ack`=1: for a read, capture `sram_rdata` into `if_rdata` or `mem_rdata` according to `owner`. Go to ARB_RESP. `sram_req` drops on the same edge.
- ARB_RESP: the owner's `ready`=1 for exactly this cycle. Next state is ARB_IDLE.
- `if_ready` = ~`if_req` | (ARB_RESP & `owner`==IF).
- `mem_ready` = ~(`mem_rd`|`mem_wr`) | (ARB_RESP & `owner`==MEM).
- Default arbitration is fixed priority, MEM over IF, because MEM holds the older instruction.
- `mem_rd` & `mem_wr` both high is illegal; it is treated as a write.
- Writes do not modify `mem_rdata`.
- Requester drops its request while ARB_BUSY: the SRAM transaction still completes and ARB_RESP still occurs. No abort.
- `sram_ack` outside ARB_BUSY is ignored.

## Timing
- Reset (async, while `rst`=0) sets state ARB_IDLE, `owner`=IF, and `sram_req`, `sram_we`, `sram_addr`, `sram_wdata`, `if_rdata`, `mem_rdata` all 0. The `ready` outputs follow their combinational equations, so each equals ~request.
- Request seen in ARB_IDLE at cycle N: `sram_req`=1 from N+1.
- `sram_ack` at cycle M ≥ N+1: `ready` and new rdata visible at M+1. Arbiter is back in ARB_IDLE at M+2.
- Minimum turnaround is 3 cycles per transaction. Back-to-back requests from both sides are serviced alternately or by priority; there is no pipelining.
- Reset asserted mid-transaction returns to ARB_IDLE immediately. The SRAM controller is reset by the same `rst`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: a `last_grant` flop is updated at each grant. On simultaneous requests, the requester not granted last wins. `last_grant` resets to IF, so MEM wins the first conflict.
- Undefined: fixed priority, MEM over IF. IF can starve under continuous MEM traffic.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (ARB_IDLE/ARB_BUSY/ARB_RESP);
  - the owner enum (OWN_IF/OWN_MEM);
  - default widths.
- Sub-module `arb_select`: combinational winner pick from `if_req`, `mem_req`, `last_grant`. It contains the `ARB_ROUND_ROBIN_EN` conditional.

## Test plan
- IF read `if_addr`=0x40, SRAM acks 2 cycles after `sram_req` rises, `sram_rdata`=0xE3A01005 -> `if_rdata`=0xE3A01005 and `if_ready` pulses 1 cycle; `sram_we`=0 throughout.
- MEM write `mem_addr`=0x400, `mem_wdata`=0x12345678 -> `sram_we`=1 with latched values. After the ack, `mem_ready` pulses; `mem_rdata` is unchanged (0).
- `if_req` and `mem_rd` rise in the same cycle:
  - fixed priority: MEM served first, then IF;
  - with `ARB_ROUND_ROBIN_EN`, after a prior MEM grant: IF served first.
- Hold `sram_ack`=0 for 20 cycles -> `sram_req` and `sram_addr` stable, both `ready`s low for active requesters, no state change.
- Pull `rst` low during ARB_BUSY -> `sram_req`=0 asynchronously; after release, the pending `if_req` is re-arbitrated from ARB_IDLE.
- `sram_ack` pulse while ARB_IDLE with no request -> no state change, no `ready` pulse, rdata unchanged.
